// File: rtl/mul8_share_sched_pkg.sv
// Shared constants and helpers for the 8x8 multiply scheduler that time-shares
// one 4x4 multiplier: state encoding, step count, and per-step shift/half selects.
package mul8_share_sched_pkg;

   // Default width of the shared multiplier operands.
   localparam int MW_DEF  = 4;

   // One 8x8 multiply takes four 4x4 partial products.
   localparam int N_STEPS = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Left shift applied to the partial product of step k: {0, MW, MW, 2*MW}.
   function automatic int step_shift(input logic [1:0] k, input int mw);
      case (k)
         2'd0:    return 0;
         2'd1:    return mw;
         2'd2:    return mw;
         default: return 2 * mw;
      endcase
   endfunction

   // Multiplicand half for step k: low for k0/k1, high for k2/k3.
   function automatic logic step_x_hi(input logic [1:0] k);
      return k[1];
   endfunction

   // Multiplier half for step k: low for k0/k2, high for k1/k3.
   function automatic logic step_y_hi(input logic [1:0] k);
      return k[0];
   endfunction

endpackage

// File: rtl/mul8_share_sched_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational; the pointer remembers
// the last requester that was granted and moves only on an accepted grant.
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic valid0,
   input  logic valid1,
   output logic gnt0,
   output logic gnt1
);

   // Index of the requester granted most recently; reset to 1 so requester 0
   // wins the first tie.
   logic last_q;

   // Grant the lone requester, or on a tie the one not granted last.
   always_comb begin
      gnt0 = en & valid0 & (~valid1 | last_q);
      gnt1 = en & valid1 & (~valid0 | ~last_q);
   end

   // Pointer update on an accepted grant only.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else if (gnt0 | gnt1) begin
         last_q <= gnt1;
      end
   end

endmodule

// File: rtl/mul8_share_sched.sv
// Scheduler sharing one external combinational MW x MW multiplier between two
// requesters. Each 2MW x 2MW request is split into four partial products issued
// on consecutive cycles and shift-accumulated into a 4MW-bit result.
//
// Handshakes: a transfer occurs on a rising edge where valid and ready are both
// high. reqN_ready is combinational, high only in IDLE for the granted requester
// whose valid is high, and never in a reset cycle; requesters hold x/y stable
// while valid is high and ready is low. rsp_valid stays high with rsp_p/rsp_id
// stable until the edge where rsp_ready is also high.
module mul8_share_sched
   import mul8_share_sched_pkg::*;
#(
   parameter int MW = MW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [2*MW-1:0]   req0_x,
   input  logic [2*MW-1:0]   req0_y,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [2*MW-1:0]   req1_x,
   input  logic [2*MW-1:0]   req1_y,
   output logic [MW-1:0]     mul_x,
   output logic [MW-1:0]     mul_y,
   input  logic [2*MW-1:0]   mul_o,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [4*MW-1:0]   rsp_p,
   output logic              busy
);

   localparam int W = 2 * MW;
   localparam logic [1:0] LAST_STEP = 2'(N_STEPS - 1);

   state_t           state_q, state_d;
   logic [1:0]       k_q;
   logic [W-1:0]     x_q, y_q;
   logic             id_q;
   logic [2*W-1:0]   acc_q;
   logic             arb_en, gnt0, gnt1, accept;
   logic [2*W-1:0]   pp;

   // Grants are only offered while idle and never during reset.
   assign arb_en = (state_q == ST_IDLE) && !rst;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (arb_en),
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign accept     = gnt0 | gnt1;

   // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after last step,
   // DONE -> IDLE when the result is taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)              state_d = ST_RUN;
         ST_RUN:  if (k_q == LAST_STEP)    state_d = ST_DONE;
         ST_DONE: if (rsp_ready)           state_d = ST_IDLE;
         default:                          state_d = ST_IDLE;
      endcase
   end

   // Operand half selection for the current step; multiplier inputs idle at 0.
   always_comb begin
      mul_x = '0;
      mul_y = '0;
      pp    = '0;
      if (state_q == ST_RUN) begin
         mul_x = step_x_hi(k_q) ? x_q[W-1:MW] : x_q[MW-1:0];
         mul_y = step_y_hi(k_q) ? y_q[W-1:MW] : y_q[MW-1:0];
         pp    = {{(2*W-2*MW){1'b0}}, mul_o} << step_shift(k_q, MW);
      end
   end

   // State register, operand latch and shift-accumulate.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= 2'd0;
         x_q     <= '0;
         y_q     <= '0;
         id_q    <= 1'b0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  x_q   <= gnt1 ? req1_x : req0_x;
                  y_q   <= gnt1 ? req1_y : req0_y;
                  id_q  <= gnt1;
                  acc_q <= '0;
                  k_q   <= 2'd0;
               end
            end
            ST_RUN: begin
               acc_q <= acc_q + pp;
               k_q   <= k_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = (state_q == ST_DONE);
   assign rsp_p     = acc_q;
   assign rsp_id    = id_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul8_share_sched.sv
// Self-checking bench for mul8_share_sched with a reference 4x4 multiply on mul_o
// and a scoreboard of expected {id, product} responses.
module tb_mul8_share_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [7:0]  req0_x, req0_y, req1_x, req1_y;
   logic [3:0]  mul_x, mul_y;
   logic [7:0]  mul_o;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [15:0] rsp_p;

   logic [16:0] exp_q[$];
   logic [16:0] mon_e;
   int          checks = 0;
   int          errors = 0;

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog got no finish required finish before time limit");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   // Reference shared multiplier
   assign mul_o = {4'b0, mul_x} * {4'b0, mul_y};

   mul8_share_sched dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_x     (req0_x),
      .req0_y     (req0_y),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_x     (req1_x),
      .req1_y     (req1_y),
      .mul_x      (mul_x),
      .mul_y      (mul_y),
      .mul_o      (mul_o),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_p      (rsp_p),
      .busy       (busy)
   );

   // Scoreboard: pop and compare on every response handshake
   always @(negedge clk) begin
      if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected got id=%0d p=%h required no response", rsp_id, rsp_p);
         end else begin
            mon_e = exp_q.pop_front();
            if ({rsp_id, rsp_p} !== mon_e) begin
               errors++;
               $display("FAIL rsp_data got id=%0d p=%h required id=%0d p=%h",
                        rsp_id, rsp_p, mon_e[16], mon_e[15:0]);
            end
         end
      end
   end

   // Driver helpers
   function automatic logic [7:0] rand_op();
      case ($urandom_range(0, 7))
         0:       return 8'h00;
         1:       return 8'hFF;
         2:       return 8'h01;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic push_exp(input logic id, input logic [7:0] x, input logic [7:0] y);
      logic [15:0] p;
      p = 16'(x) * 16'(y);
      exp_q.push_back({id, p});
   endtask

   // Hold requester id valid until accepted; called at posedge+1, returns at posedge+1.
   task automatic hold_until_accept(input logic id, output int waited, output logic other);
      waited = -1;
      other  = 1'b0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if ((id ? req1_ready : req0_ready) === 1'b1) begin
            other = id ? req0_ready : req1_ready;
            if (id) push_exp(1'b1, req1_x, req1_y);
            else    push_exp(1'b0, req0_x, req0_y);
            waited = c;
            @(posedge clk); #1;
            if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (waited < 0) begin
         errors++;
         $display("FAIL accept_timeout id=%0d got no ready required ready within 64 cycles", id);
         if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 400; c++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk); #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout got %0d pending required 0 pending", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   // Observe the four RUN cycles and the first DONE cycle after an accept.
   task automatic watch_run(input logic [31:0] seq, input logic exp_id,
                            input logic [15:0] exp_p, input string tag);
      logic [7:0] e;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         e = seq[31 - 8*i -: 8];
         checks++;
         if ({mul_x, mul_y} !== e || rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_step%0d got x=%h y=%h vld=%b busy=%b required x=%h y=%h vld=0 busy=1",
                     tag, i, mul_x, mul_y, rsp_valid, busy, e[7:4], e[3:0]);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_p !== exp_p ||
          mul_x !== 4'h0 || mul_y !== 4'h0) begin
         errors++;
         $display("FAIL %s_latency5 got vld=%b id=%0d p=%h mx=%h my=%h required vld=1 id=%0d p=%h mx=0 my=0",
                  tag, rsp_valid, rsp_id, rsp_p, mul_x, mul_y, exp_id, exp_p);
      end
      @(posedge clk); #1;
   endtask

   // Tests
   task automatic test_reset();
      rst = 1'b1;
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_x = 8'h12; req0_y = 8'h34;
      req1_valid = 1'b1; req1_x = 8'h56; req1_y = 8'h78;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_ready got r0=%b r1=%b required 0 0", req0_ready, req1_ready);
      end
      checks++;
      if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_p !== 16'h0 || busy !== 1'b0 ||
          mul_x !== 4'h0 || mul_y !== 4'h0) begin
         errors++;
         $display("FAIL reset_values got vld=%b id=%b p=%h busy=%b mx=%h my=%h required all 0",
                  rsp_valid, rsp_id, rsp_p, busy, mul_x, mul_y);
      end
      @(posedge clk); #1;
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_valid got r0=%b r1=%b busy=%b required 0 0 0", req0_ready, req1_ready, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int w; logic o;
      req0_x = 8'h12; req0_y = 8'h34; req0_valid = 1'b1;
      hold_until_accept(1'b0, w, o);
      watch_run(32'h2423_1413, 1'b0, 16'h03A8, "basic");
      wait_drain();
   endtask

   task automatic test_ffff();
      int w; logic o;
      req1_x = 8'hFF; req1_y = 8'hFF; req1_valid = 1'b1;
      hold_until_accept(1'b1, w, o);
      watch_run(32'hFFFF_FFFF, 1'b1, 16'hFE01, "ffff");
      wait_drain();
   endtask

   task automatic test_tie();
      int w; logic o;
      req0_x = 8'h0F; req0_y = 8'h10; req0_valid = 1'b1;
      req1_x = 8'h80; req1_y = 8'h02; req1_valid = 1'b1;
      hold_until_accept(1'b0, w, o);
      checks++;
      if (w != 0 || o !== 1'b0) begin
         errors++;
         $display("FAIL tie1_grant0 got wait=%0d r1=%b required wait=0 r1=0", w, o);
      end
      hold_until_accept(1'b1, w, o);
      checks++;
      if (w != 5) begin
         errors++;
         $display("FAIL tie1_throughput got wait=%0d required 5", w);
      end
      wait_drain();
      req0_x = 8'h03; req0_y = 8'h05; req0_valid = 1'b1;
      req1_x = 8'h07; req1_y = 8'h09; req1_valid = 1'b1;
      hold_until_accept(1'b0, w, o);
      checks++;
      if (w != 0 || o !== 1'b0) begin
         errors++;
         $display("FAIL tie2_grant0 got wait=%0d r1=%b required wait=0 r1=0", w, o);
      end
      hold_until_accept(1'b1, w, o);
      wait_drain();
   endtask

   task automatic test_backpressure();
      int w; logic o; int seen;
      logic [15:0] ep;
      ep = 16'(8'h5A) * 16'(8'hC3);
      rsp_ready = 1'b0;
      req0_x = 8'h5A; req0_y = 8'hC3; req0_valid = 1'b1;
      hold_until_accept(1'b0, w, o);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin seen = 1; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (seen == 0) begin
         errors++;
         $display("FAIL bp_rsp_timeout got no rsp_valid required rsp_valid within 20 cycles");
      end
      @(posedge clk); #1;
      req0_x = 8'h11; req0_y = 8'h22; req0_valid = 1'b1;
      req1_x = 8'h33; req1_y = 8'h44; req1_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_p !== ep || rsp_id !== 1'b0 || busy !== 1'b1 ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0 || mul_x !== 4'h0 || mul_y !== 4'h0) begin
            errors++;
            $display("FAIL bp_hold%0d got vld=%b p=%h id=%b busy=%b r0=%b r1=%b mx=%h my=%h required 1 %h 0 1 0 0 0 0",
                     i, rsp_valid, rsp_p, rsp_id, busy, req0_ready, req1_ready, mul_x, mul_y, ep);
         end
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release got busy=%b vld=%b required 0 0", busy, rsp_valid);
      end
      @(posedge clk); #1;
      wait_drain();
   endtask

   task automatic test_reset_mid();
      int w; logic o; int stray;
      req0_x = 8'hA7; req0_y = 8'h6B; req0_valid = 1'b1;
      hold_until_accept(1'b0, w, o);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clk);
      checks++;
      if (mul_x !== 4'hA || mul_y !== 4'hB) begin
         errors++;
         $display("FAIL rstmid_k2 got mx=%h my=%h required A B", mul_x, mul_y);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_p !== 16'h0 || mul_x !== 4'h0 || mul_y !== 4'h0) begin
         errors++;
         $display("FAIL rstmid_idle got busy=%b vld=%b p=%h mx=%h my=%h required 0 0 0000 0 0",
                  busy, rsp_valid, rsp_p, mul_x, mul_y);
      end
      stray = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (rsp_valid !== 1'b0) stray++;
      end
      @(posedge clk); #1;
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL rstmid_no_rsp got %0d valid cycles required 0", stray);
      end
      // Pointer must be back at its reset value: requester 0 wins this tie.
      req0_x = 8'h9C; req0_y = 8'h3E; req0_valid = 1'b1;
      req1_x = 8'h44; req1_y = 8'h55; req1_valid = 1'b1;
      hold_until_accept(1'b0, w, o);
      checks++;
      if (w != 0 || o !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_ptr got wait=%0d r1=%b required wait=0 r1=0", w, o);
      end
      hold_until_accept(1'b1, w, o);
      wait_drain();
   endtask

   task automatic test_edge();
      int w; logic o;
      logic [16:0] tbl [6];
      tbl = '{{1'b0, 8'h00, 8'hAB}, {1'b1, 8'h01, 8'h01}, {1'b0, 8'hFF, 8'h01},
              {1'b1, 8'h01, 8'hFF}, {1'b0, 8'h80, 8'h80}, {1'b1, 8'hFF, 8'h00}};
      for (int i = 0; i < 6; i++) begin
         if (tbl[i][16]) begin
            req1_x = tbl[i][15:8]; req1_y = tbl[i][7:0]; req1_valid = 1'b1;
         end else begin
            req0_x = tbl[i][15:8]; req0_y = tbl[i][7:0]; req0_valid = 1'b1;
         end
         hold_until_accept(tbl[i][16], w, o);
         wait_drain();
      end
   endtask

   task automatic test_random(input int n_ops);
      int started; logic a0, a1;
      started = 0;
      for (int cyc = 0; cyc < 60000; cyc++) begin
         if (started >= n_ops && !req0_valid && !req1_valid) break;
         if (!req0_valid && started < n_ops && $urandom_range(0, 1) == 1) begin
            req0_x = rand_op(); req0_y = rand_op(); req0_valid = 1'b1; started++;
         end
         if (!req1_valid && started < n_ops && $urandom_range(0, 1) == 1) begin
            req1_x = rand_op(); req1_y = rand_op(); req1_valid = 1'b1; started++;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         checks++;
         if ((req0_ready && req1_ready) || (req0_ready && !req0_valid) || (req1_ready && !req1_valid)) begin
            errors++;
            $display("FAIL rand_ready got r0=%b r1=%b v0=%b v1=%b required one ready for a valid",
                     req0_ready, req1_ready, req0_valid, req1_valid);
         end
         a0 = req0_ready & req0_valid;
         a1 = req1_ready & req1_valid;
         if (a0) push_exp(1'b0, req0_x, req0_y);
         if (a1) push_exp(1'b1, req1_x, req1_y);
         @(posedge clk); #1;
         if (a0) req0_valid = 1'b0;
         if (a1) req1_valid = 1'b0;
      end
      checks++;
      if (req0_valid || req1_valid || started != n_ops) begin
         errors++;
         $display("FAIL rand_issue got started=%0d pending=%b%b required %0d 00",
                  started, req0_valid, req1_valid, n_ops);
         req0_valid = 1'b0; req1_valid = 1'b0;
      end
      rsp_ready = 1'b1;
      wait_drain();
   endtask

   // Sequence and report
   initial begin
      test_reset();
      test_basic();
      test_ffff();
      test_tie();
      test_backpressure();
      test_reset_mid();
      test_edge();
      test_random(1000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
